adder_share_ctrl: RTL and testbench

ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

---
 rtl/adder_share_ctrl_if.sv | 32 +++
 rtl/adder_share_ctrl.sv | 145 ++++++++++++++
 tb/tb_adder_share_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_ctrl_if.sv
// Request/response bus of adder_share_ctrl.
//   req_valid[1:0]  requester i presents an operation
//   req_ready[1:0]  requester i's operation is accepted this cycle (one-hot or zero)
//   req_a/req_b     8-bit operands, requester i in bits [8i+7:8i]
//   req_sub[1:0]    0 = A+B, 1 = A-B for requester i
//   rsp_valid/rsp_ready  response handshake
//   rsp_sum/cout/ovf/id  result, carry (1 = no borrow on subtract), signed overflow, owner
//   busy            block is processing a transaction
interface adder_share_ctrl_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic        rsp_id;
  logic        busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, busy
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Two-requester 8-bit add/subtract unit sharing one 4-bit ripple slice.
// Round-robin grant in IDLE, low nibble in LO, high nibble in HI, result held in RESP.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  adder_share_ctrl_if.slave (request, response, busy)
module adder_share_ctrl (
  input  logic               clk,
  input  logic               rst,
  adder_share_ctrl_if.slave  bus
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic              cin_q;
  logic              id_q;
  logic [NIB_W-1:0]  sum_lo;
  logic              nib_c;

  logic              rsp_valid_q;
  logic [OP_W-1:0]   rsp_sum_q;
  logic              rsp_cout_q;
  logic              rsp_ovf_q;
  logic              rsp_id_q;

  logic              grant_any;
  logic              grant_id;
  logic [OP_W-1:0]   a_sel;
  logic [OP_W-1:0]   b_sel;
  logic              sub_sel;

  logic [NIB_W-1:0]  sl_a;
  logic [NIB_W-1:0]  sl_b;
  logic [NIB_W-1:0]  sl_sum;
  logic [NIB_W:0]    sl_c;

  // Round-robin arbiter: a tie goes to the requester not granted last.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!rst && state == IDLE) begin
      case (bus.req_valid)
        2'b01:   begin grant_any = 1'b1; grant_id = 1'b0;        end
        2'b10:   begin grant_any = 1'b1; grant_id = 1'b1;        end
        2'b11:   begin grant_any = 1'b1; grant_id = ~last_grant; end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = grant_any ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  // Operand lane of the granted requester.
  always_comb begin
    a_sel   = grant_id ? bus.req_a[15:8] : bus.req_a[7:0];
    b_sel   = grant_id ? bus.req_b[15:8] : bus.req_b[7:0];
    sub_sel = grant_id ? bus.req_sub[1]  : bus.req_sub[0];
  end

  // Shared 4-bit ripple slice: high nibble + nibble carry in HI, low nibble + cin otherwise.
  always_comb begin
    sl_a   = a_q[NIB_W-1:0];
    sl_b   = b_q[NIB_W-1:0];
    sl_c   = '0;
    sl_sum = '0;
    if (state == HI) begin
      sl_a    = a_q[OP_W-1:NIB_W];
      sl_b    = b_q[OP_W-1:NIB_W];
      sl_c[0] = nib_c;
    end else begin
      sl_c[0] = cin_q;
    end
    for (int i = 0; i < int'(NIB_W); i++) begin
      sl_sum[i]  = sl_a[i] ^ sl_b[i] ^ sl_c[i];
      sl_c[i+1]  = (sl_a[i] & sl_b[i]) | (sl_c[i] & (sl_a[i] ^ sl_b[i]));
    end
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      sum_lo      <= '0;
      nib_c       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            // Subtract is A + ~B + 1: invert B now, feed the +1 as carry-in.
            a_q        <= a_sel;
            b_q        <= b_sel ^ {OP_W{sub_sel}};
            cin_q      <= sub_sel;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= LO;
          end
        end
        LO: begin
          sum_lo <= sl_sum;
          nib_c  <= sl_c[NIB_W];
          state  <= HI;
        end
        HI: begin
          rsp_sum_q   <= {sl_sum, sum_lo};
          rsp_cout_q  <= sl_c[NIB_W];
          rsp_ovf_q   <= (a_q[OP_W-1] == b_q[OP_W-1]) && (sl_sum[NIB_W-1] != a_q[OP_W-1]);
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed vector table, random ops against
// an arithmetic reference model, arbitration sequence and reset-mid-transaction.
module tb_adder_share_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  adder_share_ctrl_if bus ();

  adder_share_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         hold;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                output logic [7:0] s, output logic c, output logic o);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      r  = ua + ub;
      c  = (r > 255);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    s = 8'(r);
    o = (sr > 127) || (sr < -128);
  endfunction

  // One complete transaction from requester id; entered and left at posedge+1 in IDLE.
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo, input int hold);
    int k;
    logic [1:0] exp_rdy;
    exp_rdy = (id == 1) ? 2'b10 : 2'b01;
    bus.req_valid = exp_rdy;
    bus.req_a   = (id == 1) ? {a, 8'($urandom)} : {8'($urandom), a};
    bus.req_b   = (id == 1) ? {b, 8'($urandom)} : {8'($urandom), b};
    bus.req_sub = (id == 1) ? {sub, 1'($urandom)} : {1'($urandom), sub};
    bus.rsp_ready = 1'b0;
    #1;
    k = 0;
    while (bus.req_ready != exp_rdy && k < 8) begin
      @(posedge clk); #2;
      k++;
    end
    check("grant", 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    // Scramble inputs after accept: the captured transaction must not change.
    bus.req_valid = 2'b00;
    bus.req_a = 16'($urandom);
    bus.req_b = 16'($urandom);
    bus.req_sub = 2'($urandom);
    check("busy_lo", 32'(bus.busy), 32'd1);
    check("vld_t1", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("vld_t2", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("vld_t3", 32'(bus.rsp_valid), 32'd1);
    check("sum", 32'(bus.rsp_sum), 32'(es));
    check("cout", 32'(bus.rsp_cout), 32'(ec));
    check("ovf", 32'(bus.rsp_ovf), 32'(eo));
    check("id", 32'(bus.rsp_id), 32'(id));
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 2'b11;
      #1;
      check("rdy_in_resp", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      check("hold_vld", 32'(bus.rsp_valid), 32'd1);
      check("hold_sum", 32'(bus.rsp_sum), 32'(es));
      check("hold_flags", 32'({bus.rsp_cout, bus.rsp_ovf, bus.rsp_id}), 32'({ec, eo, id[0]}));
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_vld", 32'(bus.rsp_valid), 32'd0);
    check("idle_sum_held", 32'(bus.rsp_sum), 32'(es));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_vld"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_sum"}, 32'(bus.rsp_sum), 32'd0);
    check({tag, "_flags"}, 32'({bus.rsp_cout, bus.rsp_ovf, bus.rsp_id}), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] es;
    logic       ec, eo;
    int         gcnt;
    int         gcyc[4];
    int         gid[4];
    logic [1:0] rv;

    n_checks = 0;
    n_fail   = 0;

    tbl[0] = '{id:0, a:8'h3C, b:8'h45, sub:1'b0, sum:8'h81, cout:1'b0, ovf:1'b1, hold:0};
    tbl[1] = '{id:1, a:8'h10, b:8'h20, sub:1'b1, sum:8'hF0, cout:1'b0, ovf:1'b0, hold:1};
    tbl[2] = '{id:0, a:8'hFF, b:8'h01, sub:1'b0, sum:8'h00, cout:1'b1, ovf:1'b0, hold:0};
    tbl[3] = '{id:0, a:8'h80, b:8'h01, sub:1'b1, sum:8'h7F, cout:1'b1, ovf:1'b1, hold:0};
    tbl[4] = '{id:1, a:8'h7F, b:8'h01, sub:1'b0, sum:8'h80, cout:1'b0, ovf:1'b1, hold:5};
    tbl[5] = '{id:0, a:8'h00, b:8'h00, sub:1'b1, sum:8'h00, cout:1'b1, ovf:1'b0, hold:0};
    tbl[6] = '{id:1, a:8'h0F, b:8'h01, sub:1'b0, sum:8'h10, cout:1'b0, ovf:1'b0, hold:2};
    tbl[7] = '{id:0, a:8'h80, b:8'h80, sub:1'b0, sum:8'h00, cout:1'b1, ovf:1'b1, hold:0};
    tbl[8] = '{id:1, a:8'h05, b:8'h07, sub:1'b1, sum:8'hFE, cout:1'b0, ovf:1'b0, hold:0};

    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a = 16'h0;
    bus.req_b = 16'h0;
    bus.req_sub = 2'b00;
    bus.rsp_ready = 1'b0;
    #1;
    check_reset_vals("reset");
    @(posedge clk); @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 9; i++)
      run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub,
             tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].hold);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      int         rid;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rs  = 1'($urandom);
      rid = int'($urandom_range(1, 0));
      model(ra, rb, rs, es, ec, eo);
      run_op(rid, ra, rb, rs, es, ec, eo, int'($urandom_range(3, 0)));
    end

    // Arbitration: both requesters held, consumer always ready, right after reset.
    pulse_reset();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    gcnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      rv = bus.req_ready;
      check("arb_not_both", 32'(rv == 2'b11), 32'd0);
      if (rv != 2'b00 && gcnt < 4) begin
        gcyc[gcnt] = c;
        gid[gcnt]  = (rv == 2'b10) ? 1 : 0;
        gcnt++;
      end
      @(posedge clk); #1;
    end
    check("arb_grant_count", 32'(gcnt), 32'd4);
    for (int k = 0; k < gcnt; k++) begin
      check("arb_grant_id", 32'(gid[k]), 32'(k % 2));
      if (k > 0) check("arb_interval", 32'(gcyc[k] - gcyc[k-1]), 32'd4);
    end
    bus.req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;

    // Reset while in HI: transaction abandoned, arbiter back to favouring requester 0.
    check("pre_rst_idle", 32'(bus.busy), 32'd0);
    bus.req_valid = 2'b01;
    bus.req_a = 16'h003C;
    bus.req_b = 16'h0045;
    bus.req_sub = 2'b00;
    #1;
    check("rst_t_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_hi");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 2'b11;
    #1;
    check("rst_rr_req0", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
